// File: rtl/mouse_click_filter_pkg.sv
// Shared constants and click FSM state encoding for mouse_click_filter.
// The LOCKOUT encoding exists only when MOUSE_CLICK_LOCKOUT_EN is defined.
package mouse_click_filter_pkg;

   localparam int MOUSE_POS_SIZE        = 12;
   localparam int MOUSE_DEBOUNCE_CYCLES = 65000;
   localparam int MOUSE_LOCKOUT_CYCLES  = 6500000;
   localparam int MOUSE_CNT_WIDTH       = 17;

   typedef enum logic [2:0] {
      CLICK_ST_INIT        = 3'd0,
      CLICK_ST_RELEASED    = 3'd1,
      CLICK_ST_PRESS_DEB   = 3'd2,
      CLICK_ST_PRESSED     = 3'd3,
`ifdef MOUSE_CLICK_LOCKOUT_EN
      CLICK_ST_LOCKOUT     = 3'd5,
`endif
      CLICK_ST_RELEASE_DEB = 3'd4
   } click_state_e;

   function automatic logic click_state_is_held(click_state_e s);
      return (s == CLICK_ST_PRESSED) || (s == CLICK_ST_RELEASE_DEB);
   endfunction

endpackage

// File: rtl/mouse_click_filter_if.sv
// Mouse-to-consumer signal bundle for mouse_click_filter.
// No valid/ready here: click is a one-cycle event, click_xpos/ypos qualify it and hold until the next press starts.
interface mouse_click_filter_if;
   import mouse_click_filter_pkg::*;

   logic                      enable;
   logic                      mouse_left;
   logic [MOUSE_POS_SIZE-1:0] mouse_xpos;
   logic [MOUSE_POS_SIZE-1:0] mouse_ypos;
   logic                      click;
   logic [MOUSE_POS_SIZE-1:0] click_xpos;
   logic [MOUSE_POS_SIZE-1:0] click_ypos;
   logic                      held;

   modport master (
      output enable, mouse_left, mouse_xpos, mouse_ypos,
      input  click, click_xpos, click_ypos, held
   );

   modport slave (
      input  enable, mouse_left, mouse_xpos, mouse_ypos,
      output click, click_xpos, click_ypos, held
   );

endinterface

// File: rtl/mouse_click_filter_sync_2ff.sv
// Two-flop synchroniser with asynchronous active-low reset.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/mouse_click_filter.sv
// Debounces the raw left button into one click pulse per press and latches the press-start cursor position.
// Optional post-click dead time is enabled with `define MOUSE_CLICK_LOCKOUT_EN.
module mouse_click_filter
   import mouse_click_filter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = MOUSE_DEBOUNCE_CYCLES,
   parameter int CNT_WIDTH       = MOUSE_CNT_WIDTH,
   parameter int LOCKOUT_CYCLES  = MOUSE_LOCKOUT_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst,
   mouse_click_filter_if.slave  bus,
   output click_state_e         dbg_state_o
);

   localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
`ifdef MOUSE_CLICK_LOCKOUT_EN
   localparam logic [CNT_WIDTH-1:0] LOCK_LAST = CNT_WIDTH'(LOCKOUT_CYCLES - 1);
`else
   localparam int lockout_cycles_unused = LOCKOUT_CYCLES;
`endif

   click_state_e              state_q, state_d;
   logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
   logic                      click_q, click_d;
   logic [MOUSE_POS_SIZE-1:0] xpos_q, xpos_d;
   logic [MOUSE_POS_SIZE-1:0] ypos_q, ypos_d;
   logic                      left_s;

   sync_2ff #(.WIDTH(1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (bus.mouse_left),
      .q_o (left_s)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= CLICK_ST_INIT;
         cnt_q   <= '0;
         click_q <= 1'b0;
         xpos_q  <= '0;
         ypos_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         click_q <= click_d;
         xpos_q  <= xpos_d;
         ypos_q  <= ypos_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      click_d = 1'b0;
      xpos_d  = xpos_q;
      ypos_d  = ypos_q;
      case (state_q)
         // Button must read released for a full debounce window before arming.
         CLICK_ST_INIT: begin
            if (left_s) begin
               cnt_d = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = CLICK_ST_RELEASED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         CLICK_ST_RELEASED: begin
            if (left_s) begin
               state_d = CLICK_ST_PRESS_DEB;
               cnt_d   = '0;
               xpos_d  = bus.mouse_xpos;
               ypos_d  = bus.mouse_ypos;
            end
         end
         CLICK_ST_PRESS_DEB: begin
            if (!left_s) begin
               state_d = CLICK_ST_RELEASED;
            end else if (cnt_q == DEB_LAST) begin
               state_d = CLICK_ST_PRESSED;
               click_d = bus.enable;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         CLICK_ST_PRESSED: begin
            if (!left_s) begin
               state_d = CLICK_ST_RELEASE_DEB;
               cnt_d   = '0;
            end
         end
         CLICK_ST_RELEASE_DEB: begin
            if (left_s) begin
               state_d = CLICK_ST_PRESSED;
            end else if (cnt_q == DEB_LAST) begin
`ifdef MOUSE_CLICK_LOCKOUT_EN
               state_d = CLICK_ST_LOCKOUT;
               cnt_d   = '0;
`else
               state_d = CLICK_ST_RELEASED;
`endif
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
`ifdef MOUSE_CLICK_LOCKOUT_EN
         // A button still down at expiry must go through a full debounced release again.
         CLICK_ST_LOCKOUT: begin
            if (cnt_q == LOCK_LAST) begin
               state_d = left_s ? CLICK_ST_INIT : CLICK_ST_RELEASED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
`endif
         default: begin
            state_d = CLICK_ST_INIT;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.click      = click_q;
   assign bus.click_xpos = xpos_q;
   assign bus.click_ypos = ypos_q;
   assign bus.held       = click_state_is_held(state_q);
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mouse_click_filter.sv
// Self-checking bench for mouse_click_filter with short debounce/lockout windows.
// Honors MOUSE_CLICK_LOCKOUT_EN in its expectations.
module tb_mouse_click_filter;
   import mouse_click_filter_pkg::*;

   localparam int D = 4;
   localparam int L = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   click_state_e dbg_state;
   int           checks = 0;
   int           failures = 0;
   int           click_cnt = 0;

   mouse_click_filter_if bus ();

   mouse_click_filter #(
      .DEBOUNCE_CYCLES (D),
      .CNT_WIDTH       (8),
      .LOCKOUT_CYCLES  (L)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic press(input int n);
      bus.mouse_left = 1'b1;
      wait_cyc(n);
      bus.mouse_left = 1'b0;
   endtask

   // Reference model: run length of the synchronised level decides acceptance.
   localparam int M_INIT = 0, M_UP = 1, M_DOWN = 2, M_LOCK = 3;
   int         mode = M_INIT;
   int         run = 0;
   int         lock_n = 0;
   logic       prev_ls = 1'b0;
   logic       ls;
   logic       pipe_q[$] = '{1'b0, 1'b0};
   logic       exp_click = 1'b0;
   logic       exp_held = 1'b0;
   logic [11:0] exp_x = '0;
   logic [11:0] exp_y = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode = M_INIT; run = 0; lock_n = 0; prev_ls = 1'b0;
         pipe_q.delete(); pipe_q.push_back(1'b0); pipe_q.push_back(1'b0);
         exp_click = 1'b0; exp_held = 1'b0; exp_x = '0; exp_y = '0;
      end else begin
         ls = pipe_q.pop_front();
         pipe_q.push_back(bus.mouse_left);
         run = (ls == prev_ls) ? run + 1 : 1;
         prev_ls = ls;
         exp_click = 1'b0;
         case (mode)
            M_INIT: if (!ls && run == D) mode = M_UP;
            M_UP: begin
               if (ls && run == 1) begin
                  exp_x = bus.mouse_xpos;
                  exp_y = bus.mouse_ypos;
               end
               if (ls && run == D + 1) begin
                  mode = M_DOWN;
                  exp_click = bus.enable;
               end
            end
            M_DOWN: if (!ls && run == D + 1) begin
`ifdef MOUSE_CLICK_LOCKOUT_EN
               mode = M_LOCK;
               lock_n = 0;
`else
               mode = M_UP;
`endif
            end
            default: begin
               lock_n++;
               if (lock_n == L) mode = ls ? M_INIT : M_UP;
            end
         endcase
         exp_held = (mode == M_DOWN);
      end
   end

   always @(negedge clk) begin
      check("click", 32'(bus.click), 32'(exp_click));
      check("held", 32'(bus.held), 32'(exp_held));
      check("click_xpos", 32'(bus.click_xpos), 32'(exp_x));
      check("click_ypos", 32'(bus.click_ypos), 32'(exp_y));
      if (bus.click === 1'b1) click_cnt++;
   end

   typedef struct {
      int          press_len;
      logic        en;
      logic [11:0] x;
      logic [11:0] y;
      int          exp_clicks;
   } vec_t;

   vec_t vecs[6];
   int   c0;
   int   lat;
   int   exp_t6;

   initial begin
      vecs[0] = '{1,  1'b1, 12'd11, 12'd21, 0};
      vecs[1] = '{4,  1'b1, 12'd12, 12'd22, 0};
      vecs[2] = '{5,  1'b1, 12'd13, 12'd23, 1};
      vecs[3] = '{5,  1'b0, 12'd14, 12'd24, 0};
      vecs[4] = '{30, 1'b1, 12'd15, 12'd25, 1};
      vecs[5] = '{9,  1'b0, 12'd16, 12'd26, 0};

      bus.enable = 1'b0; bus.mouse_left = 1'b0; bus.mouse_xpos = '0; bus.mouse_ypos = '0;
      rst = 1'b0;
      wait_cyc(3);
      check("rst_click", 32'(bus.click), 0);
      check("rst_held", 32'(bus.held), 0);
      check("rst_state", 32'(dbg_state), 32'(CLICK_ST_INIT));
      rst = 1'b1;
      wait_cyc(8);
      check("init_exit", 32'(dbg_state), 32'(CLICK_ST_RELEASED));

      // Clean press with latency measurement
      bus.enable = 1'b1; bus.mouse_xpos = 12'd100; bus.mouse_ypos = 12'd200;
      c0 = click_cnt;
      lat = -1;
      bus.mouse_left = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (bus.click === 1'b1) begin
            lat = i;
            check("t1_xpos", 32'(bus.click_xpos), 100);
            check("t1_ypos", 32'(bus.click_ypos), 200);
            check("t1_held", 32'(bus.held), 1);
            break;
         end
      end
      #1;
      check("t1_latency", 32'(lat), 6);
      bus.mouse_xpos = 12'd300;
      wait_cyc(13);
      bus.mouse_left = 1'b0;
      wait_cyc(24);
      check("t1_clicks", 32'(click_cnt - c0), 1);
      check("t1_xpos_hold", 32'(bus.click_xpos), 100);

      // Bounce
      c0 = click_cnt;
      press(3); wait_cyc(1); press(3);
      wait_cyc(16);
      check("t2_clicks", 32'(click_cnt - c0), 0);
      check("t2_state", 32'(dbg_state), 32'(CLICK_ST_RELEASED));

      // Held through reset
      c0 = click_cnt;
      bus.mouse_left = 1'b1;
      rst = 1'b0; wait_cyc(3); rst = 1'b1;
      wait_cyc(50);
      check("t3_state_init", 32'(dbg_state), 32'(CLICK_ST_INIT));
      bus.mouse_left = 1'b0;
      wait_cyc(16);
      check("t3_clicks", 32'(click_cnt - c0), 0);
      check("t3_state", 32'(dbg_state), 32'(CLICK_ST_RELEASED));

      // Disabled at acceptance, enabled while still held
      c0 = click_cnt;
      bus.enable = 1'b0;
      bus.mouse_left = 1'b1;
      wait_cyc(10);
      bus.enable = 1'b1;
      wait_cyc(10);
      bus.mouse_left = 1'b0;
      wait_cyc(24);
      check("t4_no_click", 32'(click_cnt - c0), 0);
      press(12);
      wait_cyc(24);
      check("t4_next_click", 32'(click_cnt - c0), 1);

      // Release bounce inside PRESSED
      c0 = click_cnt;
      press(15);
      wait_cyc(2);
      bus.mouse_left = 1'b1;
      wait_cyc(10);
      check("t5_held", 32'(bus.held), 1);
      bus.mouse_left = 1'b0;
      wait_cyc(24);
      check("t5_clicks", 32'(click_cnt - c0), 1);

      // Reset mid-debounce with the button still down
      c0 = click_cnt;
      bus.mouse_left = 1'b1;
      wait_cyc(4);
      rst = 1'b0; wait_cyc(2); rst = 1'b1;
      wait_cyc(10);
      bus.mouse_left = 1'b0;
      wait_cyc(20);
      check("rst_mid_clicks", 32'(click_cnt - c0), 0);

      // Re-press shortly after release completes
      c0 = click_cnt;
      press(15);
      for (int i = 0; i < 40 && bus.held; i++) wait_cyc(1);
      check("t6_released", 32'(bus.held), 0);
      wait_cyc(3);
      press(12);
      wait_cyc(24);
      press(12);
      wait_cyc(24);
`ifdef MOUSE_CLICK_LOCKOUT_EN
      exp_t6 = 2;
`else
      exp_t6 = 3;
`endif
      check("t6_clicks", 32'(click_cnt - c0), 32'(exp_t6));

      // Table-driven presses
      for (int v = 0; v < 6; v++) begin
         c0 = click_cnt;
         bus.enable = vecs[v].en;
         bus.mouse_xpos = vecs[v].x;
         bus.mouse_ypos = vecs[v].y;
         press(vecs[v].press_len);
         wait_cyc(24);
         check("vec_clicks", 32'(click_cnt - c0), 32'(vecs[v].exp_clicks));
         check("vec_xpos", 32'(bus.click_xpos), 32'(vecs[v].x));
         check("vec_ypos", 32'(bus.click_ypos), 32'(vecs[v].y));
      end

      // Random toggling checked by the reference model
      for (int r = 0; r < 300; r++) begin
         bus.enable = ($urandom_range(0, 3) != 0);
         bus.mouse_xpos = 12'($urandom_range(0, 4095));
         bus.mouse_ypos = 12'($urandom_range(0, 4095));
         if ($urandom_range(0, 59) == 0) begin
            rst = 1'b0; wait_cyc(1); rst = 1'b1;
         end
         bus.mouse_left = ~bus.mouse_left;
         wait_cyc($urandom_range(1, 9));
      end
      bus.mouse_left = 1'b0;
      wait_cyc(30);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
